// File: rtl/tl_resp_pkg.sv
// Shared TileLink opcode constants, the registered D-response record and the
// request alignment helper used by the SRAM responder.
package tl_resp_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // data_from_ram selects the RAM read port as the D data source; otherwise D data is 0.
    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] size;
        logic       source;
        logic       denied;
        logic       corrupt;
        logic       data_from_ram;
    } tl_d_resp_t;

    function automatic logic addr_aligned(input logic [2:0] lo, input logic [3:0] size);
        case (size)
            4'd0:    return 1'b1;
            4'd1:    return lo[0] == 1'b0;
            4'd2:    return lo[1:0] == 2'b00;
            4'd3:    return lo == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tl_resp_sram.sv
// Synchronous single-port DEPTH x 64 RAM with byte write enables; the read
// register only updates when re is high, so it holds across response stalls.
module tl_resp_sram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wmask,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;
    logic [63:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL SRAM responder: decodes Put/Get requests in a DEPTH*8-byte window
// and returns one in-order response per request through a one-entry D stage.
module tl_sram_responder
    import tl_resp_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [32:0] BASE_ADDR = 33'h0_8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic        auto_in_a_bits_source,
    input  logic [32:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic        auto_in_d_bits_source,
    output logic [2:0]  auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [33:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [33:0] LIMIT_EXT = BASE_EXT + (34'(DEPTH) << 3);

    // Handshake: a transfer happens on a channel in any cycle where valid && ready;
    // valid never waits on ready, and D holds every field while d_valid && !d_ready.
    logic        a_fire;
    logic        legal;
    logic        in_range;
    logic        opcode_ok;
    logic        is_put;
    logic        is_get;
    logic        ram_re;
    logic        ram_we;
    logic [63:0] ram_rdata;
    logic [33:0] addr_ext;
    tl_d_resp_t  new_resp;

    logic        d_valid_q, d_valid_d;
    tl_d_resp_t  resp_q, resp_d;

    logic unused_ok;
    assign unused_ok = ^auto_in_a_bits_param;

    assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;

    always_comb begin
        addr_ext  = {1'b0, auto_in_a_bits_address};
        is_put    = (auto_in_a_bits_opcode == PUT_FULL) || (auto_in_a_bits_opcode == PUT_PARTIAL);
        is_get    = (auto_in_a_bits_opcode == GET);
        opcode_ok = is_put || is_get;
        in_range  = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
        legal     = opcode_ok && in_range
                    && addr_aligned(auto_in_a_bits_address[2:0], auto_in_a_bits_size);

        new_resp               = '0;
        new_resp.opcode        = ACCESS_ACK;
        new_resp.size          = auto_in_a_bits_size;
        new_resp.source        = auto_in_a_bits_source;
        if (!legal) begin
            new_resp.denied = 1'b1;
            if (is_get) begin
                new_resp.opcode  = ACCESS_ACK_DATA;
                new_resp.corrupt = 1'b1;
            end
        end else if (is_put && auto_in_a_bits_corrupt) begin
            new_resp.denied = 1'b1;
        end else if (is_get) begin
            new_resp.opcode        = ACCESS_ACK_DATA;
            new_resp.data_from_ram = 1'b1;
        end

        ram_re = a_fire && legal && is_get;
        ram_we = a_fire && legal && is_put && !auto_in_a_bits_corrupt;
    end

    always_comb begin
        d_valid_d = d_valid_q;
        resp_d    = resp_q;
        if (a_fire) begin
            d_valid_d = 1'b1;
            resp_d    = new_resp;
        end else if (auto_in_d_ready) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_valid_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            resp_q    <= resp_d;
        end
    end

    tl_resp_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clock),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (auto_in_a_bits_address[AW+2:3]),
        .wmask (auto_in_a_bits_mask),
        .wdata (auto_in_a_bits_data),
        .rdata (ram_rdata)
    );

    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = resp_q.opcode;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = resp_q.size;
    assign auto_in_d_bits_source  = resp_q.source;
    assign auto_in_d_bits_sink    = 3'd0;
    assign auto_in_d_bits_denied  = resp_q.denied;
    assign auto_in_d_bits_corrupt = resp_q.corrupt;
    assign auto_in_d_bits_data    = resp_q.data_from_ram ? ram_rdata : 64'd0;

endmodule
